// File: rtl/vga_timing_detect_module.sv
// Measures VGA sync timing from hsync/vsync, locks onto a stable mode and
// generates data-enable plus pixel coordinates for the active region.
module vga_timing_detect_module #(
    parameter int H_ACT_START = 216,
    parameter int H_ACT       = 800,
    parameter int V_ACT_START = 27,
    parameter int V_ACT       = 600,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [10:0] h_total,
    output logic [10:0] h_sync_width,
    output logic [10:0] v_total,
    output logic [10:0] v_sync_width,
    output logic        locked,
    output logic        active,
    output logic [10:0] column_addr,
    output logic [10:0] row_addr,
    output logic        frame_start
);

    localparam logic [10:0] H_BEG  = 11'(H_ACT_START);
    localparam logic [10:0] H_END  = 11'(H_ACT_START + H_ACT);
    localparam logic [10:0] V_BEG  = 11'(V_ACT_START);
    localparam logic [10:0] V_END  = 11'(V_ACT_START + V_ACT);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    typedef enum logic [1:0] {IDLE, MEASURE, CHECK, LOCKED} state_t;

    logic        hs1, hs2, vs1, vs2;
    logic        h_fall, h_rise, v_fall, v_rise;
    logic [10:0] h_cnt, v_cnt, h_plus, v_plus;
    logic        h_ovf, v_ovf;
    logic [10:0] first_h;
    logic        first_pend, line_err;
    logic [10:0] ht_new;
    logic        last_line_err, frame_bad, tuple_match;
    logic        in_h, in_v;
    state_t      state;
    logic [7:0]  match_cnt;
    logic [10:0] ref_ht, ref_hs, ref_vt, ref_vs;

    assign h_fall = hs2 & ~hs1;
    assign h_rise = ~hs2 & hs1;
    assign v_fall = vs2 & ~vs1;
    assign v_rise = ~vs2 & vs1;
    assign h_plus = h_cnt + 11'd1;
    assign v_plus = v_cnt + 11'd1;

    // Tuple as it will be latched on this edge: with aligned syncs the last
    // line of the frame closes on the same edge as the v fall.
    assign ht_new        = h_fall ? h_plus : h_total;
    assign last_line_err = h_fall && !first_pend && (h_plus != first_h);
    assign frame_bad     = line_err | last_line_err | h_ovf | v_ovf;
    assign tuple_match   = (ht_new == ref_ht) && (h_sync_width == ref_hs) &&
                           (v_plus == ref_vt) && (v_sync_width == ref_vs);

    assign in_h = (h_cnt >= H_BEG) && (h_cnt < H_END);
    assign in_v = (v_cnt >= V_BEG) && (v_cnt < V_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            hs1 <= 1'b0; hs2 <= 1'b0; vs1 <= 1'b0; vs2 <= 1'b0;
            h_cnt <= '0; v_cnt <= '0; h_ovf <= 1'b0; v_ovf <= 1'b0;
            h_total <= '0; h_sync_width <= '0; v_total <= '0; v_sync_width <= '0;
            first_h <= '0; first_pend <= 1'b0; line_err <= 1'b0;
        end else begin
            hs1 <= hsync_in; hs2 <= hs1;
            vs1 <= vsync_in; vs2 <= vs1;

            if (h_fall) begin
                h_cnt   <= '0;
                h_ovf   <= 1'b0;
                h_total <= h_plus;
            end else if (h_cnt == CNT_MAX) begin
                h_ovf <= 1'b1;
            end else begin
                h_cnt <= h_plus;
            end
            if (h_rise)
                h_sync_width <= h_plus;

            if (v_fall) begin
                v_cnt   <= '0;
                v_ovf   <= 1'b0;
                v_total <= v_plus;
            end else if (h_fall) begin
                if (v_cnt == CNT_MAX) v_ovf <= 1'b1;
                else                  v_cnt <= v_plus;
            end
            if (v_rise)
                v_sync_width <= v_plus;

            // First complete line after the v fall is the per-frame reference.
            if (v_fall) begin
                line_err   <= 1'b0;
                first_pend <= 1'b1;
            end else if (h_fall) begin
                if (first_pend) begin
                    first_h    <= h_plus;
                    first_pend <= 1'b0;
                end else if (h_plus != first_h) begin
                    line_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            locked    <= 1'b0;
            match_cnt <= '0;
            ref_ht <= '0; ref_hs <= '0; ref_vt <= '0; ref_vs <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (v_fall) state <= MEASURE;
                end
                MEASURE: begin
                    if (v_fall) begin
                        state  <= CHECK;
                        ref_ht <= ht_new; ref_hs <= h_sync_width;
                        ref_vt <= v_plus; ref_vs <= v_sync_width;
                    end
                end
                CHECK: begin
                    if (v_fall) begin
                        if (tuple_match && !frame_bad) begin
                            if (match_cnt + 8'd1 >= LOCK_N) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else begin
                            match_cnt <= '0;
                            ref_ht <= ht_new; ref_hs <= h_sync_width;
                            ref_vt <= v_plus; ref_vs <= v_sync_width;
                        end
                    end
                end
                LOCKED: begin
                    if (h_ovf || v_ovf || (v_fall && (!tuple_match || frame_bad))) begin
                        state     <= CHECK;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        if (v_fall) begin
                            ref_ht <= ht_new; ref_hs <= h_sync_width;
                            ref_vt <= v_plus; ref_vs <= v_sync_width;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active      <= 1'b0;
            column_addr <= '0;
            row_addr    <= '0;
            frame_start <= 1'b0;
        end else begin
            active      <= locked && in_h && in_v;
            column_addr <= (locked && in_h && in_v) ? h_cnt - H_BEG : '0;
            row_addr    <= (locked && in_h && in_v) ? v_cnt - V_BEG : '0;
            frame_start <= v_fall && locked;
        end
    end

endmodule

// File: tb/tb_vga_timing_detect_module.sv
// Bench for vga_timing_detect_module: random small video modes driven frame by
// frame, outputs checked every clock against a frame-history reference model.
module tb_vga_timing_detect_module;

    localparam int HAS = 6;
    localparam int HA  = 10;
    localparam int VAS = 2;
    localparam int VA  = 4;
    localparam int LF  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [10:0] h_total, h_sync_width, v_total, v_sync_width;
    logic        locked, active, frame_start;
    logic [10:0] column_addr, row_addr;

    always #5 clk = ~clk;

    vga_timing_detect_module #(
        .H_ACT_START(HAS), .H_ACT(HA), .V_ACT_START(VAS), .V_ACT(VA), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .h_total(h_total), .h_sync_width(h_sync_width),
        .v_total(v_total), .v_sync_width(v_sync_width),
        .locked(locked), .active(active),
        .column_addr(column_addr), .row_addr(row_addr),
        .frame_start(frame_start)
    );

    typedef struct {
        int ht;
        int hs;
        int vt;
        int vs;
        bit clean;
    } frame_t;

    frame_t frames[$];
    frame_t last_rec;
    int     n_cmp = 0;
    int     n_err = 0;
    bit     chk_en = 1'b1;
    bit     first_fall = 1'b0;
    bit     exp_locked = 1'b0;
    int     sx[3];
    int     sy[3];
    bit     sr[3];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Locked after a frame boundary iff the last LF completed frames are clean
    // and carry the same timing as the frame just before them.
    function automatic bit lock_rule();
        int n = frames.size();
        if (n < LF + 1) return 1'b0;
        for (int i = n - LF; i < n; i++) begin
            if (!frames[i].clean) return 1'b0;
            if (frames[i].ht != frames[n-LF-1].ht || frames[i].hs != frames[n-LF-1].hs ||
                frames[i].vt != frames[n-LF-1].vt || frames[i].vs != frames[n-LF-1].vs)
                return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic tick(input int x, input int y, input int hs, input int vs);
        bit r, lp, vf, act, fs;
        hsync_in = (x < hs) ? 1'b0 : 1'b1;
        vsync_in = (y < vs) ? 1'b0 : 1'b1;
        r = rst;
        @(posedge clk);
        #1;
        sx[2] = sx[1]; sx[1] = sx[0]; sx[0] = x;
        sy[2] = sy[1]; sy[1] = sy[0]; sy[0] = y;
        sr[2] = sr[1]; sr[1] = sr[0]; sr[0] = r;
        if (!chk_en) return;
        lp = exp_locked;
        if (sr[0]) begin
            frames.delete();
            first_fall = 1'b0;
            exp_locked = 1'b0;
            chk("rst_locked", int'(locked), 0);
            chk("rst_active", int'(active), 0);
            chk("rst_col", int'(column_addr), 0);
            chk("rst_row", int'(row_addr), 0);
            chk("rst_fs", int'(frame_start), 0);
            chk("rst_htot", int'(h_total), 0);
            chk("rst_hsw", int'(h_sync_width), 0);
            chk("rst_vtot", int'(v_total), 0);
            chk("rst_vsw", int'(v_sync_width), 0);
            return;
        end
        vf = (sx[1] == 0) && (sy[1] == 0) && !sr[1] && !sr[2];
        fs = 1'b0;
        if (vf) begin
            if (first_fall) begin
                frames.push_back(last_rec);
                chk("h_total", int'(h_total), last_rec.ht);
                chk("h_sync_width", int'(h_sync_width), last_rec.hs);
                chk("v_total", int'(v_total), last_rec.vt);
                chk("v_sync_width", int'(v_sync_width), last_rec.vs);
            end
            first_fall = 1'b1;
            exp_locked = lock_rule();
            fs = lp;
        end
        act = lp && sx[2] >= HAS && sx[2] < HAS + HA && sy[2] >= VAS && sy[2] < VAS + VA;
        chk("locked", int'(locked), int'(exp_locked));
        chk("active", int'(active), int'(act));
        chk("column_addr", int'(column_addr), act ? sx[2] - HAS : 0);
        chk("row_addr", int'(row_addr), act ? sy[2] - VAS : 0);
        chk("frame_start", int'(frame_start), int'(fs));
    endtask

    // short_line: index of one line shortened by a clock (-1 none);
    // rst_line: line in which a 3-clock reset pulse is applied (-1 none).
    task automatic drive_frame(input int ht, input int hs, input int vt, input int vs,
                               input int short_line, input int rst_line);
        bit clean = 1'b1;
        for (int y = 0; y < vt; y++) begin
            int len = (y == short_line) ? ht - 1 : ht;
            if (y == short_line) clean = 1'b0;
            for (int x = 0; x < len; x++) begin
                if (y == rst_line && x == ht / 2)     rst = 1'b1;
                if (y == rst_line && x == ht / 2 + 3) rst = 1'b0;
                tick(x, y, hs, vs);
            end
        end
        last_rec = '{ht, hs, vt, vs, clean};
    endtask

    initial begin
        int ht1, hs1, vt1, vs1, ht2, hs2, vt2, vs2;
        for (int i = 0; i < 3; i++) begin
            sx[i] = -1; sy[i] = -1; sr[i] = 1'b1;
        end
        ht1 = $urandom_range(28, 20);
        hs1 = $urandom_range(5, 2);
        vt1 = $urandom_range(11, 8);
        vs1 = $urandom_range(2, 1);
        ht2 = ht1 + $urandom_range(3, 1);
        hs2 = $urandom_range(5, 2);
        vt2 = $urandom_range(11, 8);
        vs2 = $urandom_range(2, 1);

        // Power-up reset released mid-frame, then a stable mode locks.
        drive_frame(ht1, hs1, vt1, vs1, -1, 3);
        for (int f = 0; f < 5; f++) drive_frame(ht1, hs1, vt1, vs1, -1, -1);
        chk("lock_after_clean_frames", int'(locked), 1);

        // One short line breaks lock; clean frames relock.
        drive_frame(ht1, hs1, vt1, vs1, vt1 / 2, -1);
        for (int f = 0; f < 3; f++) drive_frame(ht1, hs1, vt1, vs1, -1, -1);
        chk("relock_after_short_line", int'(locked), 1);

        // Mode change.
        for (int f = 0; f < 4; f++) drive_frame(ht2, hs2, vt2, vs2, -1, -1);
        chk("relock_after_mode_change", int'(locked), 1);

        // Reset mid-frame while locked: full sequence needed again.
        drive_frame(ht2, hs2, vt2, vs2, -1, vt2 / 2);
        for (int f = 0; f < 5; f++) drive_frame(ht2, hs2, vt2, vs2, -1, -1);
        chk("lock_after_mid_reset", int'(locked), 1);

        // hsync stuck high: line counter saturates and lock is dropped.
        chk_en = 1'b0;
        for (int i = 0; i < 3000; i++) tick(1000, 1000, hs2, vs2);
        chk("ovf_locked", int'(locked), 0);
        chk("ovf_active", int'(active), 0);
        chk("ovf_col", int'(column_addr), 0);
        chk("ovf_h_total_held", int'(h_total), ht2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_detect_module.md
VGA_TIMING_DETECT_MODULE -- requirements
Module: vga_timing_detect_module

Interface
REQ-001 Parameters SHALL be: H_ACT_START, default 216, first active column in pixel clocks after hsync falling edge; H_ACT, default 800, active columns; V_ACT_START, default 27, first active line after vsync falling edge; V_ACT, default 600, active lines; LOCK_FRAMES, default 2, consecutive matching frames required to lock.
REQ-002 clk  input  1  pixel clock (40 MHz for 800x600@60Hz); the block SHALL have one clock only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 hsync_in  input  1  active-low horizontal sync, synchronous to clk.
REQ-005 vsync_in  input  1  active-low vertical sync, synchronous to clk.
REQ-006 h_total  output  11  measured clocks per line.
REQ-007 h_sync_width  output  11  measured hsync low clocks.
REQ-008 v_total  output  11  measured lines per frame.
REQ-009 v_sync_width  output  11  measured vsync low lines.
REQ-010 locked  output  1  timing stable for LOCK_FRAMES frames.
REQ-011 active  output  1  registered data-enable, valid only while locked.
REQ-012 column_addr  output  11  0..H_ACT-1 while active, else 0.
REQ-013 row_addr  output  11  0..V_ACT-1 while active, else 0.
REQ-014 frame_start  output  1  one-clock pulse on each vsync falling edge detected while locked.

Function
REQ-015 hsync_in and vsync_in SHALL each pass through two registers (s1, s2); fall = s2 & ~s1, rise = ~s2 & s1.
REQ-016 If hsync_in is first sampled low at edge k, h_cnt SHALL be 0 after edge k+1 and increment by 1 per clock, saturating at 2047 with a sticky h_ovf flag.
REQ-017 On h fall, h_total SHALL latch h_cnt+1; on h rise, h_sync_width SHALL latch h_cnt+1.
REQ-018 v_cnt SHALL increment on each h fall, clear to 0 on v fall, saturate at 2047 with sticky v_ovf; v fall SHALL take priority over a simultaneous h fall.
REQ-019 On v fall, v_total SHALL latch v_cnt+1; on v rise, v_sync_width SHALL latch v_cnt+1 (v_cnt sampled before any same-cycle increment).
REQ-020 Each line's h_total SHALL be compared to the frame's first-line h_total; any mismatch SHALL set sticky line_err until the next v fall.
REQ-021 The lock FSM SHALL have states IDLE, MEASURE, CHECK, LOCKED: IDLE->MEASURE on first v fall; MEASURE->CHECK on next v fall (stores reference tuple {h_total, h_sync_width, v_total, v_sync_width}).
REQ-022 In CHECK, each v fall SHALL compare the new tuple against the reference; match with no line_err/ovf increments match_cnt, otherwise match_cnt <= 0 and the reference is replaced; match_cnt reaching LOCK_FRAMES SHALL enter LOCKED.
REQ-023 In LOCKED, any v fall with tuple mismatch, line_err, h_ovf or v_ovf SHALL return to CHECK with locked <= 0 on the following clock; h_ovf or v_ovf SHALL also force CHECK immediately.
REQ-024 locked SHALL be a register equal to (state == LOCKED).
REQ-025 active SHALL be registered: active <= locked && H_ACT_START <= h_cnt < H_ACT_START+H_ACT && V_ACT_START <= v_cnt < V_ACT_START+V_ACT, so active rises after edge k+H_ACT_START+2.
REQ-026 column_addr/row_addr SHALL be registered h_cnt-H_ACT_START / v_cnt-V_ACT_START in the same cycle as active, else 0; 11-bit arithmetic, no wrap in active region.
REQ-027 frame_start SHALL pulse exactly one clock, registered, only when the v fall occurs while locked is 1 before the edge.

Reset
REQ-028 While rst is high at an edge, all outputs, counters, sync registers, flags, match_cnt and reference tuple SHALL be 0 and state SHALL be IDLE.
REQ-029 rst asserted mid-frame SHALL discard all measurement; lock SHALL require the full IDLE->MEASURE->CHECK sequence again.

Verification
REQ-030 Generator stimulus (line 1057 clocks, hsync low 128, frame 629 lines, vsync low 4 lines, edges aligned) -> h_total=1057, h_sync_width=128, v_total=629, v_sync_width=4; locked rises the clock after the 4th v fall.
REQ-031 Locked stream -> active high 800 clocks per line for 600 lines; first active pixel column_addr=0,row_addr=0; last column_addr=799,row_addr=599.
REQ-032 One line of 1056 clocks in a locked frame -> locked falls the clock after the next v fall; relock after LOCK_FRAMES further clean frames.
REQ-033 hsync_in held high 3000 clocks -> h_ovf set, locked=0, active=0 within 2 clocks of saturation.
REQ-034 rst pulsed mid-frame while locked -> all outputs 0 the next clock; locked not reasserted before the 4th v fall after release.
REQ-035 Simultaneous h fall and v fall -> v_cnt=0 (not 1) after that edge; frame_start pulses once when locked.
